// File: rtl/linebuf.sv
// Line-buffering byte FIFO between the parallel-port receiver and transmitter.
// Received bytes are held until a line completes (terminator byte, maximum
// line length, or a full buffer) and are then released to the transmitter.
// Pass-through mode releases every stored byte immediately. Bytes arriving
// while the buffer is full are dropped and counted in a saturating counter.
module linebuf #(
  parameter int         LGFLEN  = 8,
  parameter int         MAXLINE = 80,
  parameter logic [7:0] TERM_A  = 8'h0a,
  parameter logic [7:0] TERM_B  = 8'h0d
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mode,
  input  logic              i_rx_stb,
  input  logic [7:0]        i_rx_data,
  output logic              o_tx_stb,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_busy,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_empty,
  output logic              o_full,
  output logic [7:0]        o_drops
);

  localparam int              DEPTH   = 1 << LGFLEN;
  localparam logic [LGFLEN:0] DEPTH_P = (LGFLEN+1)'(DEPTH);
  localparam logic [LGFLEN:0] MAX_P   = (LGFLEN+1)'(MAXLINE);

  logic [7:0]      mem [DEPTH];

  logic [LGFLEN:0] wr_q, wr_d;
  logic [LGFLEN:0] rd_q, rd_d;
  logic [LGFLEN:0] rel_q, rel_d;
  logic [LGFLEN:0] len_q, len_d;
  logic [7:0]      drops_q, drops_d;
  logic            tx_stb_q, tx_stb_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic [LGFLEN:0] fill, len_inc;
  logic            full, wr_en, drop, accept, is_term, hit_max, full_next, release_now;

  // Pointer arithmetic, release decision and transmit-register next state.
  always_comb begin
    fill        = wr_q - rd_q;
    full        = (fill == DEPTH_P);
    wr_en       = i_rx_stb && !full;
    drop        = i_rx_stb && full;
    accept      = tx_stb_q && !i_tx_busy;

    wr_d        = wr_q + (LGFLEN+1)'(wr_en);
    rd_d        = rd_q + (LGFLEN+1)'(accept);
    len_inc     = len_q + 1'b1;

    is_term     = wr_en && ((i_rx_data == TERM_A) || (i_rx_data == TERM_B));
    hit_max     = wr_en && (len_inc == MAX_P);
    // Releasing whenever the buffer ends up full keeps a held line from
    // blocking the writer forever.
    full_next   = ((wr_d - rd_d) == DEPTH_P);
    release_now = is_term || hit_max || full_next || i_mode;

    rel_d       = release_now ? wr_d : rel_q;
    if (release_now)
      len_d = '0;
    else if (wr_en)
      len_d = len_inc;
    else
      len_d = len_q;

    drops_d     = (drop && (drops_q != 8'hff)) ? drops_q + 8'd1 : drops_q;

    // The strobe is dropped for one cycle after every accept so the data
    // register can reload from the advanced read pointer.
    tx_stb_d    = tx_stb_q;
    tx_data_d   = tx_data_q;
    if (accept) begin
      tx_stb_d = 1'b0;
    end else if (!tx_stb_q) begin
      tx_stb_d = (rd_q != rel_q);
      if (rd_q != rel_q)
        tx_data_d = mem[rd_q[LGFLEN-1:0]];
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      rel_q     <= '0;
      len_q     <= '0;
      drops_q   <= '0;
      tx_stb_q  <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      rel_q     <= rel_d;
      len_q     <= len_d;
      drops_q   <= drops_d;
      tx_stb_q  <= tx_stb_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Byte storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_reset)
      mem[wr_q[LGFLEN-1:0]] <= i_rx_data;
  end

  assign o_tx_stb  = tx_stb_q;
  assign o_tx_data = tx_data_q;
  assign o_fill    = fill;
  assign o_empty   = (fill == '0);
  assign o_full    = full;
  assign o_drops   = drops_q;

endmodule
